// File: rtl/calc_pkg.sv
// Constants shared by the calculator datapath: default result/tag widths and
// the opcode-select tag encodings carried alongside each ALU result.
package calc_pkg;

   localparam int CALC_DATA_W = 6;
   localparam int CALC_TAG_W  = 3;

   typedef enum logic [CALC_TAG_W-1:0] {
      TAG_NONE = 3'd0,
      TAG_ADD  = 3'd1,
      TAG_SUB  = 3'd2,
      TAG_MUL  = 3'd3,
      TAG_DIV  = 3'd4,
      TAG_NEG  = 3'd5,
      TAG_LOAD = 3'd6
   } calc_tag_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced level request. History resets to 1 so a
// request already held high when reset releases does not count as a new press.
module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic i_level,
   output logic o_pulse
);

   logic r_hist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_hist <= 1'b1;
      else       r_hist <= i_level;
   end

   assign o_pulse = i_level & ~r_hist;

endmodule

// File: rtl/result_stack.sv
// Tagged LIFO of ALU results held in a circular buffer (base pointer + count),
// with replace-top on simultaneous push/pop, optional overwrite-oldest and sticky flags.
module result_stack
   import calc_pkg::*;
#(
   parameter int DATA_W    = CALC_DATA_W,
   parameter int TAG_W     = CALC_TAG_W,
   parameter int DEPTH     = 8,
   parameter bit OVERWRITE = 1'b0,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic              flag_clr,
   input  logic              rdflag_clr,
   output logic [DATA_W-1:0] data_top,
   output logic [TAG_W-1:0]  tag_top,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              ovf_flag,
   output logic              udf_flag
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int SUM_W = CNT_W + 1;
   localparam int ENT_W = TAG_W + DATA_W;
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Sums never reach 2*DEPTH, so a single conditional subtract wraps them.
   function automatic logic [IDX_W-1:0] f_wrap(input logic [SUM_W-1:0] v);
      logic [SUM_W-1:0] w;
      w = (v >= DEPTH_S) ? v - DEPTH_S : v;
      return w[IDX_W-1:0];
   endfunction

   logic [ENT_W-1:0]  r_mem [DEPTH];
   logic [IDX_W-1:0]  r_bot;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_data_top;
   logic [TAG_W-1:0]  r_tag_top;
   logic              r_ovf;
   logic              r_udf;

   logic              w_push_ev, w_pop_ev, w_full, w_empty;
   logic [IDX_W-1:0]  w_top_idx, w_nxt_idx, w_bot_inc, w_new_top_idx;
   logic [IDX_W-1:0]  w_nxt_bot, w_wr_idx;
   logic [CNT_W-1:0]  w_nxt_count;
   logic              w_wr_en, w_set_ovf, w_set_udf;
   logic [ENT_W-1:0]  w_new_top;

   edge_pulse u_push_edge (.clk(clk), .reset(reset), .i_level(push), .o_pulse(w_push_ev));
   edge_pulse u_pop_edge  (.clk(clk), .reset(reset), .i_level(pop),  .o_pulse(w_pop_ev));

   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);

   assign w_top_idx     = f_wrap(SUM_W'(r_bot) + SUM_W'(r_count) - SUM_W'(1));
   assign w_nxt_idx     = f_wrap(SUM_W'(r_bot) + SUM_W'(r_count));
   assign w_bot_inc     = f_wrap(SUM_W'(r_bot) + SUM_W'(1));
   assign w_new_top_idx = f_wrap(SUM_W'(w_nxt_bot) + SUM_W'(w_nxt_count) - SUM_W'(1));

   always_comb begin
      w_nxt_count = r_count;
      w_nxt_bot   = r_bot;
      w_wr_en     = 1'b0;
      w_wr_idx    = w_nxt_idx;
      w_set_ovf   = 1'b0;
      w_set_udf   = 1'b0;
      if (w_push_ev && w_pop_ev) begin
         w_wr_en = 1'b1;
         if (w_empty) begin
            w_nxt_count = r_count + CNT_W'(1);
            w_set_udf   = 1'b1;
         end else begin
            w_wr_idx = w_top_idx;
         end
      end else if (w_push_ev) begin
         if (!w_full) begin
            w_wr_en     = 1'b1;
            w_nxt_count = r_count + CNT_W'(1);
         end else begin
            w_set_ovf = 1'b1;
            if (OVERWRITE) begin
               w_wr_en   = 1'b1;
               w_wr_idx  = r_bot;
               w_nxt_bot = w_bot_inc;
            end
         end
      end else if (w_pop_ev) begin
         if (!w_empty) w_nxt_count = r_count - CNT_W'(1);
         else          w_set_udf   = 1'b1;
      end
   end

   // Every write lands on the slot that becomes the new top, so bypass memory.
   always_comb begin
      w_new_top = '0;
      if (w_wr_en)                w_new_top = {tag_in, data_in};
      else if (w_nxt_count != '0) w_new_top = r_mem[w_new_top_idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_bot      <= '0;
         r_data_top <= '0;
         r_tag_top  <= '0;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
      end else begin
         r_count                 <= w_nxt_count;
         r_bot                   <= w_nxt_bot;
         {r_tag_top, r_data_top} <= w_new_top;
         if (w_set_ovf)     r_ovf <= 1'b1;
         else if (flag_clr) r_ovf <= 1'b0;
         if (w_set_udf)       r_udf <= 1'b1;
         else if (rdflag_clr) r_udf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) r_mem[w_wr_idx] <= {tag_in, data_in};
   end

   assign data_top = r_data_top;
   assign tag_top  = r_tag_top;
   assign count    = r_count;
   assign full     = w_full;
   assign empty    = w_empty;
   assign ovf_flag = r_ovf;
   assign udf_flag = r_udf;

endmodule

// File: tb/tb_result_stack.sv
// Directed bench for result_stack at DEPTH=4: one drop-on-full instance and one
// overwrite-oldest instance driven by the same stimulus.
module tb_result_stack;

   localparam int DW = 6;
   localparam int TW = 3;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset, push, pop, flag_clr, rdflag_clr;
   logic [DW-1:0] data_in;
   logic [TW-1:0] tag_in;

   logic [DW-1:0] d0_data, d1_data;
   logic [TW-1:0] d0_tag, d1_tag;
   logic [CW-1:0] d0_cnt, d1_cnt;
   logic          d0_full, d0_empty, d0_ovf, d0_udf;
   logic          d1_full, d1_empty, d1_ovf, d1_udf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_stack #(.DATA_W(DW), .TAG_W(TW), .DEPTH(4), .OVERWRITE(1'b0)) u_drop (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in), .tag_in(tag_in),
      .flag_clr(flag_clr), .rdflag_clr(rdflag_clr), .data_top(d0_data), .tag_top(d0_tag),
      .count(d0_cnt), .full(d0_full), .empty(d0_empty), .ovf_flag(d0_ovf), .udf_flag(d0_udf));

   result_stack #(.DATA_W(DW), .TAG_W(TW), .DEPTH(4), .OVERWRITE(1'b1)) u_ovw (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in), .tag_in(tag_in),
      .flag_clr(flag_clr), .rdflag_clr(rdflag_clr), .data_top(d1_data), .tag_top(d1_tag),
      .count(d1_cnt), .full(d1_full), .empty(d1_empty), .ovf_flag(d1_ovf), .udf_flag(d1_udf));

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One idle edge (clears request history), then one edge with the given inputs;
   // returns at the following negedge with outputs settled.
   task automatic step(input logic pu, input logic po, input logic fc, input logic rc,
                       input int d, input int t);
      @(negedge clk);
      push = pu; pop = po; flag_clr = fc; rdflag_clr = rc;
      data_in = DW'(d); tag_in = TW'(t);
      @(negedge clk);
      push = 1'b0; pop = 1'b0; flag_clr = 1'b0; rdflag_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; flag_clr = 1'b0; rdflag_clr = 1'b0;
      data_in = '0; tag_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      chk("rst_count", d0_cnt, 0);
      chk("rst_data", d0_data, 0);
      chk("rst_tag", d0_tag, 0);
      chk("rst_empty", d0_empty, 1);
      chk("rst_full", d0_full, 0);
      chk("rst_ovf", d0_ovf, 0);
      chk("rst_udf", d0_udf, 0);

      // Three pushes then three pops
      step(1, 0, 0, 0, 5, 1);
      chk("p1_data", d0_data, 5);
      step(1, 0, 0, 0, 9, 2);
      step(1, 0, 0, 0, 12, 3);
      chk("p3_count", d0_cnt, 3);
      chk("p3_data", d0_data, 12);
      chk("p3_tag", d0_tag, 3);
      chk("p3_empty", d0_empty, 0);
      chk("p3_full", d0_full, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("pop1_data", d0_data, 9);
      chk("pop1_tag", d0_tag, 2);
      step(0, 1, 0, 0, 0, 0);
      chk("pop2_data", d0_data, 5);
      step(0, 1, 0, 0, 0, 0);
      chk("pop3_data", d0_data, 0);
      chk("pop3_tag", d0_tag, 0);
      chk("pop3_empty", d0_empty, 1);

      // Fill past full on both variants
      for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, i, 0);
      chk("fill_full", d0_full, 1);
      chk("fill_full_ow", d1_full, 1);
      chk("fill_ovf_pre", d0_ovf, 0);
      step(1, 0, 0, 0, 5, 0);
      chk("drop_data", d0_data, 4);
      chk("drop_count", d0_cnt, 4);
      chk("drop_ovf", d0_ovf, 1);
      chk("ow_count", d1_cnt, 4);
      chk("ow_data", d1_data, 5);
      chk("ow_ovf", d1_ovf, 1);
      step(0, 0, 1, 0, 0, 0);
      chk("clr_ovf", d0_ovf, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("ow_pop1", d1_data, 4);
      chk("drop_pop1", d0_data, 3);
      step(0, 1, 0, 0, 0, 0);
      chk("ow_pop2", d1_data, 3);
      step(0, 1, 0, 0, 0, 0);
      chk("ow_pop3", d1_data, 2);
      chk("drop_pop3", d0_data, 1);
      step(0, 1, 0, 0, 0, 0);
      chk("ow_pop4", d1_data, 0);
      chk("ow_empty", d1_empty, 1);
      chk("drop_empty", d0_empty, 1);

      // Underflow and clear priority
      step(0, 1, 0, 0, 0, 0);
      chk("udf_set", d0_udf, 1);
      chk("udf_count", d0_cnt, 0);
      step(0, 1, 0, 1, 0, 0);
      chk("udf_set_over_clr", d0_udf, 1);
      step(0, 0, 0, 1, 0, 0);
      chk("udf_clr", d0_udf, 0);

      // Replace-top and push+pop on empty
      step(1, 0, 0, 0, 7, 4);
      chk("rep_pre_data", d0_data, 7);
      step(1, 1, 0, 0, 20, 5);
      chk("rep_count", d0_cnt, 1);
      chk("rep_data", d0_data, 20);
      chk("rep_tag", d0_tag, 5);
      chk("rep_udf", d0_udf, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("rep_pop_empty", d0_empty, 1);
      step(1, 1, 0, 0, 3, 6);
      chk("pp_empty_count", d0_cnt, 1);
      chk("pp_empty_data", d0_data, 3);
      chk("pp_empty_udf", d0_udf, 1);
      step(0, 1, 0, 1, 0, 0);

      // Request held through reset release must not act
      @(negedge clk);
      reset = 1'b1;
      push = 1'b1; data_in = 6'd30; tag_in = 3'd1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_rst_count", d0_cnt, 0);
      push = 1'b0;
      repeat (2) @(negedge clk);
      push = 1'b1; data_in = 6'd11; tag_in = 3'd5;
      repeat (10) @(negedge clk);
      push = 1'b0;
      chk("hold10_count", d0_cnt, 1);
      chk("hold10_data", d0_data, 11);
      chk("hold10_tag", d0_tag, 5);
      step(1, 0, 0, 0, 13, 6);
      chk("pre_arst_count", d0_cnt, 2);

      // Asynchronous reset between clock edges
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_count", d0_cnt, 0);
      chk("arst_data", d0_data, 0);
      chk("arst_tag", d0_tag, 0);
      chk("arst_empty", d0_empty, 1);
      chk("arst_ovf", d0_ovf, 0);
      chk("arst_udf", d0_udf, 0);
      @(negedge clk);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/result_stack.md
# result_stack

Parametrised tagged result stack, successor to the fixed 8-deep calculator LIFO. Sits between the ALU and the display driver on the 300 Hz calculator clock: stores each ALU result with its opcode-select tag on a `push` request and exposes the top entry continuously. Adds configurable width and depth, an occupancy count, simultaneous push/pop (replace-top), an optional overwrite-oldest mode, and separate sticky overflow and underflow flags.

## Interface
- `DATA_W`, default 6: result width.
- `TAG_W`, default 3: opcode-select tag width.
- `DEPTH`, default 8: number of entries, must be ≥ 2; any value is allowed, not only powers of 2.
- `OVERWRITE`, default 0: 0 means a push when full is dropped; 1 means a push when full discards the oldest entry.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`.
- Ports:
  - `clk` in 1: calculator clock (300 Hz domain).
  - `reset` in 1: one clock; reset is asynchronous and active-high.
  - `push` in 1: level request from debouncer; acts on its rising edge.
  - `pop` in 1: level request from debouncer; acts on its rising edge.
  - `data_in` in DATA_W: ALU result.
  - `tag_in` in TAG_W: opcode-select tag.
  - `flag_clr` in 1: clears `ovf_flag`.
  - `rdflag_clr` in 1: clears `udf_flag`.
  - `data_top` out DATA_W: top result, registered.
  - `tag_top` out TAG_W: top tag, registered.
  - `count` out CNT_W: number of stored entries.
  - `full` out 1: `count == DEPTH`.
  - `empty` out 1: `count == 0`.
  - `ovf_flag` out 1: sticky; set by a push when full.
  - `udf_flag` out 1: sticky; set by a pop when empty.

## Operation
- Events:
  - `push_ev = push & ~push_q` and `pop_ev = pop & ~pop_q`.
  - `push_q` and `pop_q` are registered copies of the inputs.
- Storage is a circular buffer: base pointer `bot` and `count`. Top index is `(bot + count - 1)` wrapped at DEPTH by explicit compare, not by masking.
- Push only:
  - Not full: write `{tag_in, data_in}` at top+1, then `count+1`.
  - Full with OVERWRITE=0: no write; set `ovf_flag`.
  - Full with OVERWRITE=1: write at the slot at `bot`, advance `bot` by 1 (wrapped), leave `count` unchanged, set `ovf_flag`.
- Pop only:
  - Not empty: `count-1`; data is not cleared.
  - Empty: no change; set `udf_flag`.
- Push and pop in the same cycle:
  - Not empty: overwrite the top entry; `count` and `bot` unchanged; no flags.
  - Empty: act as push only; set `udf_flag`.
- Flags: a set has priority over `flag_clr` / `rdflag_clr` in the same cycle.
- `data_top` / `tag_top` show the new top after each update. Both are 0 whenever `count == 0`.
- `full` and `empty` decode combinationally from registered `count`.

## Timing
- Reset values:
  - `count=0`, `bot=0`, `data_top=0`, `tag_top=0`, `ovf_flag=0`, `udf_flag=0`.
  - `push_q=1`, `pop_q=1`. A request held high through reset release must be released and re-pressed before it acts.
  - Memory contents are not reset.
- Latency: if `push` is first sampled high at edge k, then `count`, `data_top`, `tag_top` and the flags are valid after edge k. There is one event per rising edge of the request, regardless of how long it is held.
- Reset asserted mid-operation clears state immediately; there is no partial write.
- Inputs `data_in` / `tag_in` are sampled only at the event edge.

## Structure
- Shared package `calc_pkg` holds the default DATA_W / TAG_W constants and the opcode-select tag encodings shared with the ALU and display.
- Sub-module `edge_pulse`: rising-edge detector with reset-to-1 history. Instantiated twice, once for push and once for pop.
- Storage, pointer logic and flags live in `result_stack` itself.

## Test plan
Configuration for all scenarios: DEPTH=4, OVERWRITE=0 unless noted.

- Reset, then 3 pushes of data 5, 9, 12 with tag 1, 2, 3 -> `count`=3, `data_top`=12, `tag_top`=3, `empty`=0, `full`=0. Then 3 pops -> `data_top` goes 9, then 5, then 0; `empty`=1.
- 5 pushes of 1..5 -> `full`=1 after the 4th push. The 5th push is dropped: `data_top`=4, `ovf_flag`=1. Pulse `flag_clr` -> `ovf_flag`=0.
- Same 5 pushes with OVERWRITE=1 -> `count`=4, `data_top`=5, `ovf_flag`=1. Then 4 pops -> tops 4, 3, 2, then 0 with `empty`=1; value 1 never appears.
- Pop when empty -> `udf_flag`=1, `count`=0. Pulse `rdflag_clr` in the same cycle as a second empty pop -> `udf_flag` stays 1.
- Push 7, then push 20 and pop in the same cycle -> `count`=1, `data_top`=20. Simultaneous push of 3 and pop when empty -> `count`=1, `data_top`=3, `udf_flag`=1.
- Hold `push` high across reset release -> no event. Hold `push` high for 10 cycles -> exactly one entry. Assert `reset` mid-sequence with `count`=2 -> all outputs return to their reset values asynchronously.
